// File: rtl/ps2_encoder.sv
// PS/2 device-side transmitter: byte queue feeding an 11-bit odd-parity frame serializer.
// The host may abort a frame by holding the bus clock low; the aborted byte is resent in full.
module ps2_encoder #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic       ps2_clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       host_inhibit,
   output logic       ps2_data_out,
   output logic       ps2_clk_en,
   output logic       busy,
   output logic       full,
   output logic [4:0] fifo_count,
   output logic       frame_done,
   output logic       overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_GAP,
      S_INHIBIT
   } state_t;

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] count;
   state_t      state_q, state_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic        gap_q, gap_d;
   logic [7:0]  byte_q, byte_d;
   logic        data_out_q, data_out_d;
   logic        clk_en_q, clk_en_d;
   logic        frame_done_q, frame_done_d;
   logic        overflow_q, overflow_d;
   logic        empty;
   logic        push;
   logic        pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign count = wr_ptr_q - rd_ptr_q;
   // full is evaluated before this edge's pop, so a write when full is dropped even if a pop coincides
   assign push  = wr_en && !full;

   assign fifo_count   = 5'(count);
   assign busy         = (state_q != S_IDLE);
   assign ps2_data_out = data_out_q;
   assign ps2_clk_en   = clk_en_q;
   assign frame_done   = frame_done_q;
   assign overflow     = overflow_q;

   // Outputs are registered, so each branch assigns the bus values of the state being entered
   always_comb begin
      state_d      = state_q;
      bit_idx_d    = bit_idx_q;
      gap_d        = gap_q;
      byte_d       = byte_q;
      data_out_d   = 1'b1;
      clk_en_d     = 1'b0;
      frame_done_d = 1'b0;
      pop          = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty && !host_inhibit) begin
               state_d    = S_START;
               byte_d     = mem_q[rd_ptr_q[AW-1:0]];
               data_out_d = 1'b0;
               clk_en_d   = 1'b1;
            end
         end
         S_START: begin
            if (host_inhibit) begin
               state_d = S_INHIBIT;
            end else begin
               state_d    = S_DATA;
               bit_idx_d  = 3'd0;
               data_out_d = byte_q[0];
               clk_en_d   = 1'b1;
            end
         end
         S_DATA: begin
            if (host_inhibit) begin
               state_d = S_INHIBIT;
            end else if (bit_idx_q == 3'd7) begin
               state_d    = S_PARITY;
               data_out_d = ~^byte_q;
               clk_en_d   = 1'b1;
            end else begin
               bit_idx_d  = bit_idx_q + 3'd1;
               data_out_d = byte_q[bit_idx_d];
               clk_en_d   = 1'b1;
            end
         end
         S_PARITY: begin
            if (host_inhibit) begin
               state_d = S_INHIBIT;
            end else begin
               state_d  = S_STOP;
               clk_en_d = 1'b1;
            end
         end
         S_STOP: begin
            state_d      = S_GAP;
            gap_d        = 1'b0;
            pop          = 1'b1;
            frame_done_d = 1'b1;
         end
         S_GAP: begin
            if (gap_q) state_d = S_IDLE;
            else       gap_d   = 1'b1;
         end
         S_INHIBIT: begin
            if (!host_inhibit) begin
               state_d = S_GAP;
               gap_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
      overflow_d = overflow_q | (wr_en & full);
   end

   always_ff @(posedge ps2_clk) begin
      if (rst_n && push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge ps2_clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         bit_idx_q    <= '0;
         gap_q        <= 1'b0;
         byte_q       <= '0;
         data_out_q   <= 1'b1;
         clk_en_q     <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         bit_idx_q    <= bit_idx_d;
         gap_q        <= gap_d;
         byte_q       <= byte_d;
         data_out_q   <= data_out_d;
         clk_en_q     <= clk_en_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
      end
   end

endmodule

// File: tb/tb_ps2_encoder.sv
// Bench for ps2_encoder: a monitor deserializes every bus frame and checks it against a
// queue of expected frames; the stimulus thread adds cycle-exact checks of timing and flags.
module tb_ps2_encoder;

   logic       ps2_clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       host_inhibit = 1'b0;
   logic       ps2_data_out;
   logic       ps2_clk_en;
   logic       busy;
   logic       full;
   logic [4:0] fifo_count;
   logic       frame_done;
   logic       overflow;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int frames_rx = 0;
   int aborts = 0;
   int dones = 0;
   logic [10:0] exp_q[$];
   int start_q[$];

   ps2_encoder #(.FIFO_DEPTH(16)) dut (
      .ps2_clk     (ps2_clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .host_inhibit(host_inhibit),
      .ps2_data_out(ps2_data_out),
      .ps2_clk_en  (ps2_clk_en),
      .busy        (busy),
      .full        (full),
      .fifo_count  (fifo_count),
      .frame_done  (frame_done),
      .overflow    (overflow)
   );

   always #5 ps2_clk = ~ps2_clk;
   always @(posedge ps2_clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 20000", cyc);
      $fatal(1, "watchdog");
   end

   // Frame bit i is the bit on the bus i cycles after the start bit
   function automatic logic [10:0] frame_of(input logic [7:0] b);
      return {1'b1, ~^b, b, 1'b0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge ps2_clk);
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      @(negedge ps2_clk);
      wr_en   = 1'b0;
   endtask

   task automatic wait_idle(input int bound, input string name);
      bit ok;
      ok = 1'b0;
      clk_n(2);
      for (int k = 0; k < bound; k++) begin
         if (!busy && fifo_count == 5'd0) begin
            ok = 1'b1;
            break;
         end
         @(negedge ps2_clk);
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: idle not reached, got busy=%0b fifo_count=%0d required busy=0 fifo_count=0 within %0d cycles",
                  name, busy, fifo_count, bound);
      end
   endtask

   initial begin : monitor
      bit          in_frame;
      bit          exp_done;
      int          nbits;
      logic [10:0] bits;
      logic [10:0] e;
      in_frame = 1'b0;
      exp_done = 1'b0;
      nbits    = 0;
      bits     = '0;
      forever begin
         @(negedge ps2_clk);
         if (exp_done) begin
            chk("frame_done_pulse", 32'(frame_done), 1);
            exp_done = 1'b0;
         end else if (frame_done === 1'b1) begin
            chk("frame_done_spurious", 32'(frame_done), 0);
         end
         if (frame_done === 1'b1) dones++;
         if (!in_frame) begin
            if (ps2_clk_en === 1'b1) begin
               in_frame = 1'b1;
               bits     = '0;
               bits[0]  = ps2_data_out;
               nbits    = 1;
               start_q.push_back(cyc);
            end
         end else if (ps2_clk_en !== 1'b1) begin
            aborts++;
            in_frame = 1'b0;
         end else begin
            bits[nbits] = ps2_data_out;
            nbits++;
            if (nbits == 11) begin
               in_frame = 1'b0;
               frames_rx++;
               exp_done = 1'b1;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL frame_unexpected: got frame 0x%03h required no frame", bits);
               end else begin
                  e = exp_q.pop_front();
                  chk("frame_bits", 32'(bits), 32'(e));
               end
            end
         end
      end
   end

   initial begin : stimulus
      int s0, d0, a0, f0;
      clk_n(3);
      chk("rst_data_out", 32'(ps2_data_out), 1);
      chk("rst_clk_en", 32'(ps2_clk_en), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_count", 32'(fifo_count), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      rst_n = 1'b1;
      clk_n(2);

      // 0x1C: time-ordered bits 0,0,0,1,1,1,0,0,0,0,1
      exp_q.push_back(11'b100_0011_1000);
      write_byte(8'h1C);
      chk("t1_count_after_write", 32'(fifo_count), 1);
      chk("t1_idle_after_write", 32'(busy), 0);
      @(negedge ps2_clk);
      chk("t1_start_bit", 32'(ps2_data_out), 0);
      chk("t1_start_clk_en", 32'(ps2_clk_en), 1);
      chk("t1_busy", 32'(busy), 1);
      clk_n(10);
      chk("t1_stop_bit", 32'(ps2_data_out), 1);
      chk("t1_stop_clk_en", 32'(ps2_clk_en), 1);
      chk("t1_count_at_stop", 32'(fifo_count), 1);
      chk("t1_no_early_done", 32'(frame_done), 0);
      @(negedge ps2_clk);
      chk("t1_done", 32'(frame_done), 1);
      chk("t1_count_popped", 32'(fifo_count), 0);
      chk("t1_gap_clk_en", 32'(ps2_clk_en), 0);
      clk_n(2);
      chk("t1_idle_again", 32'(busy), 0);

      // 0xF0: data 0,0,0,0,1,1,1,1 parity 1; second write lands on the pop edge
      exp_q.push_back(11'b111_1110_0000);
      write_byte(8'hF0);
      clk_n(11);
      exp_q.push_back(frame_of(8'h55));
      write_byte(8'h55);
      chk("t2_push_pop_count", 32'(fifo_count), 1);
      chk("t2_done", 32'(frame_done), 1);
      wait_idle(60, "t2_idle");

      // back-to-back bytes
      s0 = start_q.size();
      d0 = dones;
      exp_q.push_back(frame_of(8'h12));
      exp_q.push_back(frame_of(8'h34));
      wr_en = 1'b1;
      wr_data = 8'h12;
      @(negedge ps2_clk);
      wr_data = 8'h34;
      @(negedge ps2_clk);
      wr_en = 1'b0;
      wait_idle(80, "t3_idle");
      chk("t3_starts", 32'(start_q.size()), 32'(s0 + 2));
      if (start_q.size() >= s0 + 2) chk("t3_spacing", 32'(start_q[s0+1] - start_q[s0]), 14);
      chk("t3_dones", 32'(dones), 32'(d0 + 2));

      // fill while inhibited, one write beyond capacity
      f0 = frames_rx;
      host_inhibit = 1'b1;
      for (int i = 0; i < 17; i++) begin
         wr_en = 1'b1;
         wr_data = 8'(i);
         if (i < 16) exp_q.push_back(frame_of(8'(i)));
         @(negedge ps2_clk);
         if (i == 15) begin
            chk("t4_full_at_16", 32'(full), 1);
            chk("t4_no_overflow_yet", 32'(overflow), 0);
         end
      end
      wr_en = 1'b0;
      chk("t4_count", 32'(fifo_count), 16);
      chk("t4_full", 32'(full), 1);
      chk("t4_overflow", 32'(overflow), 1);
      chk("t4_held_idle", 32'(busy), 0);
      host_inhibit = 1'b0;
      wait_idle(400, "t4_drain");
      chk("t4_frames", 32'(frames_rx), 32'(f0 + 16));
      chk("t4_overflow_sticky", 32'(overflow), 1);

      // abort during data bit 3 of 0xA5, then full retransmit
      a0 = aborts;
      exp_q.push_back(frame_of(8'hA5));
      write_byte(8'hA5);
      @(negedge ps2_clk);
      chk("t5_start", 32'(ps2_data_out), 0);
      clk_n(4);
      chk("t5_bit3", 32'(ps2_data_out), 0);
      chk("t5_bit3_clk_en", 32'(ps2_clk_en), 1);
      host_inhibit = 1'b1;
      @(negedge ps2_clk);
      chk("t5_abort_clk_en", 32'(ps2_clk_en), 0);
      chk("t5_abort_data", 32'(ps2_data_out), 1);
      chk("t5_abort_busy", 32'(busy), 1);
      chk("t5_abort_count", 32'(fifo_count), 1);
      clk_n(3);
      chk("t5_hold_clk_en", 32'(ps2_clk_en), 0);
      host_inhibit = 1'b0;
      clk_n(2);
      chk("t5_gap_clk_en", 32'(ps2_clk_en), 0);
      chk("t5_gap_busy", 32'(busy), 1);
      @(negedge ps2_clk);
      chk("t5_idle", 32'(busy), 0);
      @(negedge ps2_clk);
      chk("t5_restart", 32'(ps2_data_out), 0);
      chk("t5_restart_clk_en", 32'(ps2_clk_en), 1);
      clk_n(10);
      chk("t5_stop_count", 32'(fifo_count), 1);
      chk("t5_stop_clk_en", 32'(ps2_clk_en), 1);
      @(negedge ps2_clk);
      chk("t5_popped", 32'(fifo_count), 0);
      wait_idle(40, "t5_idle");
      chk("t5_one_abort", 32'(aborts), 32'(a0 + 1));

      // reset during PARITY with three bytes queued
      a0 = aborts;
      f0 = frames_rx;
      wr_en = 1'b1;
      wr_data = 8'h11;
      @(negedge ps2_clk);
      wr_data = 8'h22;
      @(negedge ps2_clk);
      wr_data = 8'h33;
      @(negedge ps2_clk);
      wr_en = 1'b0;
      clk_n(8);
      chk("t6_parity", 32'(ps2_data_out), 1);
      chk("t6_parity_clk_en", 32'(ps2_clk_en), 1);
      chk("t6_count", 32'(fifo_count), 3);
      rst_n = 1'b0;
      @(negedge ps2_clk);
      chk("t6_rst_data", 32'(ps2_data_out), 1);
      chk("t6_rst_clk_en", 32'(ps2_clk_en), 0);
      chk("t6_rst_count", 32'(fifo_count), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_done", 32'(frame_done), 0);
      chk("t6_rst_overflow", 32'(overflow), 0);
      rst_n = 1'b1;
      s0 = start_q.size();
      clk_n(20);
      chk("t6_stays_idle", 32'(busy), 0);
      chk("t6_no_restart", 32'(start_q.size()), 32'(s0));
      chk("t6_no_frames", 32'(frames_rx), 32'(f0));
      chk("t6_abort", 32'(aborts), 32'(a0 + 1));

      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
